// File: rtl/asteroid_wave_ctrl.sv
// Level/wave scheduler for the asteroid-quad array; every decision is taken on vsync.
// Optional attract wave on quad 0 while idle: define ASTWAVE_ATTRACT_EN.
module asteroid_wave_ctrl #(
  parameter int NQUAD        = 4,
  parameter int START_QUADS  = 1,
  parameter int CLEAR_FRAMES = 120,
  parameter int LEVEL_W      = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               vsync,
  input  logic               game_begin,
  input  logic               game_over,
  input  logic [NQUAD-1:0]   quad_empty,
  output logic [NQUAD-1:0]   new_level,
  output logic [NQUAD-1:0]   quad_enable,
  output logic [LEVEL_W-1:0] level,
  output logic               level_start,
  output logic               busy
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SPAWN = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_CLEAR = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam int FC_W = (CLEAR_FRAMES > 1) ? $clog2(CLEAR_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(CLEAR_FRAMES - 1);
  localparam int N_W = LEVEL_W + 5;

  logic [2:0]         state_r;
  logic [LEVEL_W-1:0] level_r;
  logic [NQUAD-1:0]   en_r;
  logic [NQUAD-1:0]   cleared_r;
  logic [FC_W-1:0]    frame_cnt_r;
  logic               start_r;
  logic [NQUAD-1:0]   mask_s;
  logic [NQUAD-1:0]   hits_s;
  logic [NQUAD-1:0]   cleared_nxt_s;

  // Lowest n quads active, n = START_QUADS + level - 1, naturally capped at NQUAD.
  function automatic logic [NQUAD-1:0] wave_mask(input logic [LEVEL_W-1:0] lvl);
    logic [N_W-1:0]   n;
    logic [NQUAD-1:0] m;
    n = N_W'(START_QUADS) + N_W'(lvl) - N_W'(1);
    m = '0;
    for (int i = 0; i < NQUAD; i++) begin
      m[i] = (N_W'(i) < n);
    end
    return m;
  endfunction

  assign mask_s        = wave_mask(level_r);
  assign hits_s        = quad_empty & ~cleared_r;
  assign cleared_nxt_s = cleared_r | hits_s;

  // Wave sequencing; game_over pre-empts every other transition.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r     <= ST_IDLE;
      level_r     <= '0;
      en_r        <= '0;
      cleared_r   <= '0;
      frame_cnt_r <= '0;
      start_r     <= 1'b0;
    end else begin
      start_r <= 1'b0;
      if (vsync) begin
        case (state_r)
          ST_IDLE: begin
            if (game_begin && !game_over) begin
              state_r   <= ST_SPAWN;
              level_r   <= LEVEL_W'(1);
              cleared_r <= '0;
            end
          end
          ST_SPAWN: begin
            if (game_over) begin
              state_r <= ST_OVER;
              en_r    <= '0;
            end else begin
              state_r   <= ST_PLAY;
              en_r      <= mask_s;
              cleared_r <= ~mask_s;
              start_r   <= 1'b1;
            end
          end
          ST_PLAY: begin
            if (game_over) begin
              state_r <= ST_OVER;
              en_r    <= '0;
            end else begin
              cleared_r <= cleared_nxt_s;
              if (&cleared_nxt_s) begin
                state_r     <= ST_CLEAR;
                frame_cnt_r <= '0;
                en_r        <= '0;
              end else begin
                en_r <= en_r & ~hits_s;
              end
            end
          end
          ST_CLEAR: begin
            if (game_over) begin
              state_r <= ST_OVER;
              en_r    <= '0;
            end else if (frame_cnt_r == FC_LAST) begin
              state_r <= ST_SPAWN;
              if (level_r != '1) begin
                level_r <= level_r + LEVEL_W'(1);
              end
            end else begin
              frame_cnt_r <= frame_cnt_r + FC_W'(1);
            end
          end
          ST_OVER: begin
            en_r <= '0;
            if (!game_over && !game_begin) begin
              state_r <= ST_IDLE;
              level_r <= '0;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            level_r <= '0;
            en_r    <= '0;
          end
        endcase
      end
    end
  end

`ifdef ASTWAVE_ATTRACT_EN
  logic attract_r;

  // Attract respawn request: armed while away from IDLE, re-armed by quad 0 emptying.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      attract_r <= 1'b1;
    end else if (state_r != ST_IDLE) begin
      attract_r <= 1'b1;
    end else if (vsync) begin
      attract_r <= quad_empty[0];
    end else begin
      attract_r <= attract_r;
    end
  end

  // Quad 0 stays enabled during the attract wave.
  always_comb begin
    quad_enable = en_r;
    if (state_r == ST_IDLE) begin
      quad_enable[0] = 1'b1;
    end else begin
      quad_enable = en_r;
    end
  end
`else
  assign quad_enable = en_r;
`endif

  // Spawn strobe is held from SPAWN entry until the vsync that starts the wave.
  always_comb begin
    new_level = '0;
    if (state_r == ST_SPAWN && !game_over) begin
      new_level = mask_s;
    end
`ifdef ASTWAVE_ATTRACT_EN
    else if (state_r == ST_IDLE) begin
      new_level[0] = attract_r;
    end
`endif
    else begin
      new_level = '0;
    end
  end

  assign busy        = (state_r == ST_SPAWN) || (state_r == ST_PLAY) || (state_r == ST_CLEAR);
  assign level       = level_r;
  assign level_start = start_r;

endmodule

// File: tb/tb_asteroid_wave_ctrl.sv
// Randomized bench for asteroid_wave_ctrl with a per-vsync behavioural model of the wave rules.
module tb_asteroid_wave_ctrl;
  localparam int NQ   = 4;
  localparam int SQ   = 1;
  localparam int CF   = 120;
  localparam int LW   = 8;
  localparam int LMAX = (1 << LW) - 1;
  localparam int FULL = (1 << NQ) - 1;

  logic          clk;
  logic          resetN;
  logic          vsync;
  logic          game_begin;
  logic          game_over;
  logic [NQ-1:0] quad_empty;
  logic [NQ-1:0] new_level;
  logic [NQ-1:0] quad_enable;
  logic [LW-1:0] level;
  logic          level_start;
  logic          busy;

  asteroid_wave_ctrl #(.NQUAD(NQ), .START_QUADS(SQ), .CLEAR_FRAMES(CF), .LEVEL_W(LW)) dut (
    .clk(clk), .resetN(resetN), .vsync(vsync), .game_begin(game_begin), .game_over(game_over),
    .quad_empty(quad_empty), .new_level(new_level), .quad_enable(quad_enable),
    .level(level), .level_start(level_start), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {M_IDLE, M_SPAWN, M_PLAY, M_CLEAR, M_OVER} phase_t;

  phase_t m_phase;
  int     m_level;
  int     m_en;
  int     m_cleared;
  int     m_cnt;
  int     m_start;
  int     err_cnt;
  int     chk_cnt;
  bit     fast;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_mask(input int lvl);
    int n;
    n = SQ + lvl - 1;
    if (n > NQ) n = NQ;
    if (n < 0) n = 0;
    return (1 << n) - 1;
  endfunction

  task automatic model_reset();
    m_phase = M_IDLE; m_level = 0; m_en = 0; m_cleared = 0; m_cnt = 0; m_start = 0;
  endtask

  task automatic model_step(input logic vs, input logic gb, input logic go, input logic [NQ-1:0] qe);
    m_start = 0;
    if (!vs) return;
    case (m_phase)
      M_IDLE: if (gb && !go) begin m_phase = M_SPAWN; m_level = 1; m_cleared = 0; end
      M_SPAWN: begin
        if (go) begin m_phase = M_OVER; m_en = 0; end
        else begin
          m_phase = M_PLAY; m_en = exp_mask(m_level); m_cleared = FULL & ~m_en; m_start = 1;
        end
      end
      M_PLAY: begin
        if (go) begin m_phase = M_OVER; m_en = 0; end
        else begin
          for (int i = 0; i < NQ; i++) begin
            if (qe[i] && !m_cleared[i]) begin
              m_cleared = m_cleared | (1 << i);
              m_en = m_en & ~(1 << i);
            end
          end
          if (m_cleared == FULL) begin m_phase = M_CLEAR; m_cnt = 0; m_en = 0; end
        end
      end
      M_CLEAR: begin
        if (go) begin m_phase = M_OVER; m_en = 0; end
        else if (m_cnt == CF - 1) begin
          m_phase = M_SPAWN;
          m_level = (m_level < LMAX) ? m_level + 1 : LMAX;
        end else m_cnt++;
      end
      M_OVER: if (!go && !gb) begin m_phase = M_IDLE; m_level = 0; end
      default: ;
    endcase
  endtask

  // One clock: drive, compare at the falling edge, then advance the model on the rising edge.
  task automatic tick(input logic vs, input logic gb, input logic go, input logic [NQ-1:0] qe);
    int exp_nl;
    int exp_busy;
    vsync = vs; game_begin = gb; game_over = go; quad_empty = qe;
    @(negedge clk);
    exp_nl   = (m_phase == M_SPAWN && !go) ? exp_mask(m_level) : 0;
    exp_busy = (m_phase == M_SPAWN || m_phase == M_PLAY || m_phase == M_CLEAR) ? 1 : 0;
    chk("level", 32'(level), 32'(m_level));
    chk("quad_enable", 32'(quad_enable), 32'(m_en));
    chk("new_level", 32'(new_level), 32'(exp_nl));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("level_start", 32'(level_start), 32'(m_start));
    @(posedge clk);
    model_step(vs, gb, go, qe);
    #1;
  endtask

  // Random idle gap (quad_empty noise ignored off-vsync), then the vsync cycle itself.
  task automatic frame(input logic gb, input logic go, input logic [NQ-1:0] qe);
    int g;
    g = fast ? 1 : int'($urandom_range(1, 3));
    repeat (g) tick(1'b0, gb, go, NQ'($urandom));
    tick(1'b1, gb, go, qe);
  endtask

  task automatic do_reset();
    resetN = 1'b0; vsync = 1'b0; game_begin = 1'b0; game_over = 1'b0; quad_empty = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    resetN = 1'b1;
  endtask

  initial begin
    int budget;
    err_cnt = 0; chk_cnt = 0; fast = 1'b0;
    do_reset();
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    repeat (3) frame(1'b0, 1'b0, '0);
    chk("idle_enable", 32'(quad_enable), 32'h0);
    chk("idle_new_level", 32'(new_level), 32'h0);

    frame(1'b1, 1'b0, '0);
    chk("spawn1_strobe", 32'(new_level), 32'h1);
    frame(1'b1, 1'b0, '0);
    chk("wave1_start", 32'(level_start), 32'h1);
    chk("wave1_enable", 32'(quad_enable), 32'h1);
    chk("wave1_level", 32'(level), 32'h1);

    frame(1'b1, 1'b0, 4'b0001);
    chk("clear1_enable", 32'(quad_enable), 32'h0);
    repeat (CF) frame(1'b1, 1'b0, NQ'($urandom));
    chk("spawn2_level", 32'(level), 32'h2);
    chk("spawn2_strobe", 32'(new_level), 32'h3);
    frame(1'b1, 1'b0, '0);
    chk("wave2_enable", 32'(quad_enable), 32'h3);

    frame(1'b1, 1'b0, 4'b0011);
    repeat (CF) frame(1'b1, 1'b0, '0);
    frame(1'b1, 1'b0, '0);
    chk("wave3_enable", 32'(quad_enable), 32'h7);
    for (int f = 1; f <= 20; f++) begin
      logic [NQ-1:0] qe;
      qe = NQ'($urandom) & 4'b1000;
      if (f == 10) qe = qe | 4'b0010;
      if (f > 10 && f < 20) qe = qe | (NQ'($urandom) & 4'b0010);
      if (f == 20) qe = qe | 4'b0101;
      frame(1'b1, 1'b0, qe);
      if (f >= 10 && f < 20) chk("wave3_q1_dropped", 32'(quad_enable), 32'h5);
    end
    chk("wave3_clear_enable", 32'(quad_enable), 32'h0);
    chk("wave3_clear_busy", 32'(busy), 32'h1);

    repeat (CF - 1) frame(1'b1, 1'b0, '0);
    frame(1'b1, 1'b1, '0);
    chk("over_level", 32'(level), 32'h3);
    chk("over_new_level", 32'(new_level), 32'h0);
    chk("over_busy", 32'(busy), 32'h0);
    frame(1'b1, 1'b0, '0);
    chk("over_hold_begin", 32'(level), 32'h3);
    frame(1'b0, 1'b0, '0);
    chk("idle_after_over", 32'(level), 32'h0);

    for (int k = 0; k < 600; k++) begin
      frame(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 29) == 0), NQ'($urandom));
    end

    do_reset();
    fast = 1'b1;
    frame(1'b1, 1'b0, '0);
    budget = 40000;
    while (m_level != LMAX && budget > 0) begin
      frame(1'b1, 1'b0, 4'b1111);
      budget--;
    end
    if (budget == 0) chk("sat_timeout", 32'h1, 32'h0);
    chk("sat_level", 32'(level), 32'hFF);
    chk("sat_strobe", 32'(new_level), 32'hF);
    frame(1'b1, 1'b0, '0);
    frame(1'b1, 1'b0, 4'b1111);
    repeat (CF) frame(1'b1, 1'b0, '0);
    chk("sat_hold_level", 32'(level), 32'hFF);
    chk("sat_hold_strobe", 32'(new_level), 32'hF);
    frame(1'b1, 1'b0, '0);
    chk("sat_play_enable", 32'(quad_enable), 32'hF);

    #3 resetN = 1'b0;
    #1;
    chk("async_rst_level", 32'(level), 32'h0);
    chk("async_rst_enable", 32'(quad_enable), 32'h0);
    chk("async_rst_new_level", 32'(new_level), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_start", 32'(level_start), 32'h0);
    model_reset();
    @(posedge clk);
    #1 resetN = 1'b1;
    repeat (3) frame(1'b0, 1'b0, NQ'($urandom));

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
